// File: rtl/approx_mult_pkg.sv
// Shared widths, types and constants for the approximate-multiplier
// error characterisation blocks.
package approx_mult_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_CNT_W = 17;
    localparam int DEF_SUM_W = 32;

    typedef logic [DEF_W-1:0]   operand_t;
    typedef logic [2*DEF_W-1:0] product_t;

    localparam logic [DEF_SUM_W-1:0] SUM_MAX = '1;

endpackage

// File: rtl/approx_mult_err_distance.sv
// Error distance between an exact and an approximate product, plus a flag
// telling whether the approximation overshoots.
module err_distance
    import approx_mult_pkg::*;
(
    input  product_t exact,
    input  product_t appr,
    output product_t ed,
    output logic     over
);

    logic [2*DEF_W:0] diff;

    // The sign bit of the widened difference is set exactly when appr > exact.
    assign diff = {1'b0, exact} - {1'b0, appr};
    assign over = diff[2*DEF_W];
    assign ed   = over ? product_t'(-diff) : diff[2*DEF_W-1:0];

endmodule

// File: rtl/approx_mult_err_accum.sv
// Two-stage error statistics accumulator scoring an approximate multiplier
// against the exact product over a fixed number of samples.
module approx_mult_err_accum
    import approx_mult_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int NUM_SAMPLES = 65536,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SUM_W       = DEF_SUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic [2*W-1:0]   z_approx,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] over_cnt,
    output logic [SUM_W-1:0] sum_ed,
    output logic [2*W-1:0]   max_ed,
    output logic             done
);

    localparam logic [CNT_W-1:0] TARGET  = CNT_W'(NUM_SAMPLES);
    localparam logic [SUM_W-1:0] SUM_SAT = SUM_W'(SUM_MAX);

    logic [CNT_W-1:0] acc_cnt;
    logic             v1;
    logic             accept;
    logic [2*W-1:0]   exact_q;
    logic [2*W-1:0]   appr_q;
    logic [2*W-1:0]   ed;
    logic             over;
    logic [SUM_W:0]   sum_next;

    assign in_ready = !clear && (acc_cnt < TARGET);
    assign accept   = in_valid && in_ready;

    // Stage 1 control: accepted-sample count and the stage valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= '0;
            v1      <= 1'b0;
        end else if (clear) begin
            acc_cnt <= '0;
            v1      <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) acc_cnt <= acc_cnt + 1'b1;
        end
    end

    // NOTE: pure datapath registers carry no reset; v1 qualifies every use.
    always_ff @(posedge clk) begin
        if (accept) begin
            exact_q <= {{W{1'b0}}, x} * {{W{1'b0}}, y};
            appr_q  <= z_approx;
        end
    end

    err_distance u_err_distance (
        .exact (exact_q),
        .appr  (appr_q),
        .ed    (ed),
        .over  (over)
    );

    // One spare carry bit detects accumulator overflow for saturation.
    assign sum_next = {1'b0, sum_ed} + (SUM_W + 1)'(ed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            over_cnt   <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
            done       <= 1'b0;
        end else if (clear) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            over_cnt   <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
            done       <= 1'b0;
        end else if (v1) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (ed != '0)  err_cnt  <= err_cnt + 1'b1;
            if (over)      over_cnt <= over_cnt + 1'b1;
            sum_ed <= sum_next[SUM_W] ? SUM_SAT : sum_next[SUM_W-1:0];
            if (ed > max_ed) max_ed <= ed;
            if (sample_cnt == TARGET - 1'b1) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_approx_mult_err_accum.sv
// Directed self-checking bench for approx_mult_err_accum with a 4-sample target.
module tb_approx_mult_err_accum;

    localparam int W     = 8;
    localparam int NS    = 4;
    localparam int CNT_W = 17;
    localparam int SUM_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic [2*W-1:0]   z_approx;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] over_cnt;
    logic [SUM_W-1:0] sum_ed;
    logic [2*W-1:0]   max_ed;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;
    int accepts;

    always #5 clk = ~clk;

    approx_mult_err_accum #(
        .W(W), .NUM_SAMPLES(NS), .CNT_W(CNT_W), .SUM_W(SUM_W)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .z_approx(z_approx),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .over_cnt(over_cnt),
        .sum_ed(sum_ed), .max_ed(max_ed), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag, input int sc, input int ec, input int oc,
                               input int sm, input int mx, input int dn);
        check({tag, "/sample_cnt"}, 64'(sample_cnt), 64'(sc));
        check({tag, "/err_cnt"},    64'(err_cnt),    64'(ec));
        check({tag, "/over_cnt"},   64'(over_cnt),   64'(oc));
        check({tag, "/sum_ed"},     64'(sum_ed),     64'(sm));
        check({tag, "/max_ed"},     64'(max_ed),     64'(mx));
        check({tag, "/done"},       64'(done),       64'(dn));
    endtask

    // Inputs change on the falling edge; the next rising edge consumes them.
    task automatic drive(input logic v, input int xi, input int yi, input int zi);
        @(negedge clk);
        in_valid = v;
        x        = W'(xi);
        y        = W'(yi);
        z_approx = (2*W)'(zi);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        #1;
        check({tag, "/ready_in_clear"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        x = '0; y = '0; z_approx = '0;
        #12 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_stats("reset", 0, 0, 0, 0, 0, 0);
        check("reset/in_ready", 64'(in_ready), 64'd1);

        // Exact sample
        drive(1'b1, 3, 5, 15);
        idle(2);
        check_stats("exact", 1, 0, 0, 0, 0, 0);

        // Underestimate by 256, then overestimate by 2
        drive(1'b1, 255, 255, 64769);
        idle(2);
        check_stats("under", 2, 1, 0, 256, 256, 0);
        drive(1'b1, 1, 1, 3);
        idle(2);
        check_stats("over", 3, 2, 1, 258, 256, 0);

        // Target reached: in_valid held for 6 cycles, only 4 accepted
        do_clear("clr1");
        check_stats("clr1", 0, 0, 0, 0, 0, 0);
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, i + 2, i + 3, (i + 2) * (i + 3));
            check($sformatf("target/ready%0d", i), 64'(in_ready), 64'(i < NS));
            if (in_ready) accepts++;
            if (i == 4) begin
                check("target/cnt_before", 64'(sample_cnt), 64'd3);
                check("target/done_before", 64'(done), 64'd0);
            end
            if (i == 5) begin
                check("target/cnt_at", 64'(sample_cnt), 64'd4);
                check("target/done_at", 64'(done), 64'd1);
            end
        end
        idle(2);
        check("target/accepts", 64'(accepts), 64'(NS));
        check_stats("target", 4, 0, 0, 0, 0, 1);
        check("target/in_ready", 64'(in_ready), 64'd0);

        // Stream with a gap every third cycle, each product off by +1
        do_clear("clr2");
        check("clr2/done", 64'(done), 64'd0);
        for (int i = 0; i < 6; i++) begin
            if (i % 3 == 2) drive(1'b0, 0, 0, 0);
            else            drive(1'b1, 200 + i, 150 + i, (200 + i) * (150 + i) + 1);
        end
        idle(2);
        check_stats("stream", 4, 4, 4, 4, 1, 1);

        // Clear with one sample in flight after three retired
        do_clear("clr3");
        for (int i = 0; i < 3; i++) drive(1'b1, 10, 10, 90);
        idle(2);
        check_stats("pre_flush", 3, 3, 0, 30, 10, 0);
        drive(1'b1, 2, 2, 0);
        do_clear("flush");
        check_stats("flush", 0, 0, 0, 0, 0, 0);
        idle(2);
        check_stats("flush_after", 0, 0, 0, 0, 0, 0);
        check("flush/in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset between clock edges
        drive(1'b1, 7, 9, 60);
        drive(1'b1, 4, 4, 20);
        idle(2);
        check_stats("pre_rst", 2, 2, 1, 7, 4, 0);
        #2 rst = 1'b1;
        #1;
        check_stats("async_rst", 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        drive(1'b1, 12, 12, 140);
        idle(2);
        check_stats("restart", 1, 1, 0, 4, 4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
